// File: rtl/microsequencer.sv
// microsequencer: next-microaddress generator with one-deep return register, memory stall and sticky trap
module microsequencer #(
  parameter int AW = 5,
  parameter logic [AW-1:0] START_ADDR = 5'd0,
  parameter logic [AW-1:0] ABS_ADDR = 5'd1,
  parameter logic [AW-1:0] RIND_ADDR = 5'd5,
  parameter logic [AW-1:0] TRAP_ADDR = 5'd24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    nssel,
  input  logic [AW-1:0] dbin,
  input  logic [2:0]    memcntl,
  input  logic [2:0]    opcode,
  input  logic [1:0]    amode,
  input  logic          zflag,
  input  logic          mem_wait,
  output logic [AW-1:0] address,
  output logic          stall,
  output logic          trap
);
  logic [AW-1:0] cur_addr, ret_addr, ret_next, mem_t, reg_t;
  logic ret_valid, valid_next, trap_set;
  always_comb begin
    mem_t = TRAP_ADDR;
    reg_t = TRAP_ADDR;
    case (opcode)
      3'd0: begin mem_t = AW'(10); reg_t = AW'(15); end
      3'd1: begin mem_t = AW'(11); reg_t = AW'(16); end
      3'd2: begin mem_t = AW'(12); reg_t = AW'(17); end
      3'd3: begin mem_t = AW'(14); reg_t = AW'(14); end
      3'd4: begin mem_t = AW'(9);  reg_t = AW'(9);  end
      3'd5: begin mem_t = AW'(19); reg_t = AW'(19); end
      3'd6: begin mem_t = AW'(21); reg_t = AW'(21); end
      default: ;
    endcase
  end
  // reset overrides a pending stall so the abort is visible in the same cycle
  assign stall = !reset && memcntl != 3'b000 && mem_wait;
  always_comb begin
    address = cur_addr;
    ret_next = ret_addr;
    valid_next = ret_valid;
    trap_set = 1'b0;
    if (reset)
      address = START_ADDR;
    else if (!stall)
      case (nssel)
        2'b00: address = dbin;
        2'b01:
          if (opcode == 3'd7 || amode == 2'b11) begin
            address = TRAP_ADDR;
            trap_set = 1'b1;
          end else if (amode == 2'b00)
            address = reg_t;
          else begin
            address = amode == 2'b01 ? ABS_ADDR : RIND_ADDR;
            ret_next = mem_t;
            valid_next = 1'b1;
          end
        2'b10:
          if (ret_valid) begin
            address = ret_addr;
            valid_next = 1'b0;
          end else begin
            address = TRAP_ADDR;
            trap_set = 1'b1;
          end
        default: address = zflag ? dbin : dbin + AW'(1);
      endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      cur_addr <= START_ADDR;
      ret_addr <= '0;
      ret_valid <= 1'b0;
      trap <= 1'b0;
    end else if (!stall) begin
      cur_addr <= address;
      ret_addr <= ret_next;
      ret_valid <= valid_next;
      trap <= trap | trap_set;
    end
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: randomized scoreboard bench against a table-driven sequencing model
module tb_microsequencer;
  logic clock = 0, reset = 1, zflag = 0, mem_wait = 0;
  logic [1:0] nssel = 0, amode = 0;
  logic [4:0] dbin = 0, address;
  logic [2:0] memcntl = 0, opcode = 0;
  logic stall, trap;
  typedef struct { int a; int s; int t; } exp_t;
  exp_t q[$];
  int ncmp = 0, nfail = 0;
  int mem_tab[8] = '{10, 11, 12, 14, 9, 19, 21, 24};
  int reg_tab[8] = '{15, 16, 17, 14, 9, 19, 21, 24};
  int m_cur = 0, m_ret = 0, m_rv = 0, m_trap = 0;

  microsequencer dut (
    .clock(clock), .reset(reset), .nssel(nssel), .dbin(dbin), .memcntl(memcntl),
    .opcode(opcode), .amode(amode), .zflag(zflag), .mem_wait(mem_wait),
    .address(address), .stall(stall), .trap(trap)
  );

  always #5 clock = ~clock;

  task automatic drive(input int r, input int ns, input int db, input int mc,
                       input int op, input int am, input int z, input int w);
    int ea, st, nret, nrv, tset;
    @(posedge clock);
    #1;
    reset = r[0]; nssel = ns[1:0]; dbin = db[4:0]; memcntl = mc[2:0];
    opcode = op[2:0]; amode = am[1:0]; zflag = z[0]; mem_wait = w[0];
    st = (r == 0 && mc != 0 && w != 0) ? 1 : 0;
    nret = m_ret; nrv = m_rv; tset = 0; ea = m_cur;
    if (r != 0) ea = 0;
    else if (st == 0)
      case (ns)
        0: ea = db;
        1: if (op == 7 || am == 3) begin ea = 24; tset = 1; end
           else if (am == 0) ea = reg_tab[op];
           else begin ea = (am == 1) ? 1 : 5; nret = mem_tab[op]; nrv = 1; end
        2: if (m_rv != 0) begin ea = m_ret; nrv = 0; end
           else begin ea = 24; tset = 1; end
        default: ea = (z != 0) ? db : (db + 1) % 32;
      endcase
    q.push_back('{ea, st, m_trap});
    if (r != 0) begin m_cur = 0; m_ret = 0; m_rv = 0; m_trap = 0; end
    else if (st == 0) begin m_cur = ea; m_ret = nret; m_rv = nrv; m_trap = m_trap | tset; end
  endtask

  always @(negedge clock)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      ncmp++;
      if (int'(address) != e.a || int'(stall) != e.s || int'(trap) != e.t) begin
        nfail++;
        $display("FAIL seq t=%0t: address/stall/trap got %0d/%0d/%0d expected %0d/%0d/%0d",
                 $time, address, stall, trap, e.a, e.s, e.t);
      end
    end

  initial begin
    int ns, op, am, wait_cycles;
    drive(1, 0, 23, 0, 0, 0, 0, 0);
    drive(1, 0, 23, 0, 0, 0, 0, 0);
    drive(0, 0, 23, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 3, 6, 0, 0, 0, 1, 0);
    drive(0, 3, 6, 0, 0, 0, 0, 0);
    drive(0, 3, 31, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 7, 2, 0, 0, 0, 1);
    drive(0, 0, 7, 2, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 2, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 7, 0, 0, 0);
    drive(0, 0, 12, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 2, 3, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // opcode 7 is only combined with amode 00/11 so every case lands on an unambiguous trap
    repeat (2000) begin
      ns = $urandom_range(3);
      am = $urandom_range(3);
      op = $urandom_range(7);
      if (op == 7 && (am == 1 || am == 2)) op = $urandom_range(6);
      drive(($urandom_range(59) == 0) ? 1 : 0, ns, $urandom_range(31),
            ($urandom_range(1) == 0) ? 0 : $urandom_range(7), op, am,
            $urandom_range(1), ($urandom_range(2) == 0) ? 1 : 0);
    end
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      nfail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-address generator for the microcoded controller.
- Each cycle it takes the sequencing fields of the current control word (nssel, dbin, memcntl), the IR opcode and addressing-mode fields, and the ALU zero flag.
- From these it produces the 5-bit microaddress that the control store registers on the next clock edge.
- It holds a one-deep return register for addressing-mode subroutines, stalls on memory wait, and traps on illegal opcodes and modes.

Parameters:
- AW, 5, microaddress width
- START_ADDR, 5'd0, address issued in reset (start0)
- ABS_ADDR, 5'd1, amode 01 subroutine entry (abdm1)
- RIND_ADDR, 5'd5, amode 10 subroutine entry (adrm1)
- TRAP_ADDR, 5'd24, illegal-opcode/mode/return handler entry

Ports:
- clock  in  1  rising-edge clock shared with the control store
- reset  in  1  synchronous, active-high
- nssel  in  2  next-state select field of the current control word
- dbin  in  AW  branch target field of the current control word
- memcntl  in  3  memory control field; nonzero means a memory cycle is active
- opcode  in  3  IR opcode
- amode  in  2  IR addressing mode
- zflag  in  1  ALU zero flag
- mem_wait  in  1  memory not ready
- address  out  AW  microaddress to the control store (combinational from inputs and state)
- stall  out  1  high while the current microinstruction is being held
- trap  out  1  registered, sticky trap indicator

Behaviour:
- Registers:
  - cur_addr (last issued address)
  - ret_addr (AW bits)
  - ret_valid
  - trap
- reset high:
  - address = START_ADDR, stall = 0.
  - On the edge: cur_addr <= START_ADDR, ret_addr <= 0, ret_valid <= 0, trap <= 0.
  - The control store therefore presents rom[START_ADDR] on the first cycle after release.
- Stall:
  - Condition: memcntl != 000 and mem_wait = 1.
  - address = cur_addr and stall = 1; all state is held and nssel is ignored.
  - Stall has priority over every nssel action.
- Without a stall, nssel is decoded as follows:
  - 00 jump: address = dbin.
  - 01 dispatch: target from the mode-dependent opcode table (see below). amode meanings:
    - 00 register: address = reg_table[opcode].
    - 01: address = ABS_ADDR; ret_addr <= mem_table[opcode]; ret_valid <= 1.
    - 10: address = RIND_ADDR; ret_addr <= mem_table[opcode]; ret_valid <= 1.
    - 11: illegal; address = TRAP_ADDR, trap <= 1.
  - 10 return:
    - ret_valid = 1: address = ret_addr, ret_valid <= 0.
    - ret_valid = 0: address = TRAP_ADDR, trap <= 1.
  - 11 branch-on-zero: address = zflag ? dbin : dbin + 1, computed modulo 2^AW (31 wraps to 0).
- Opcode tables (opcode: mem_table / reg_table):
  - 0 LD: 10 / 15
  - 1 ST: 11 / 16
  - 2 OP: 12 / 17
  - 3 TEST: 14 / 14
  - 4 BRZ: 9 / 9
  - 5 POP: 19 / 19
  - 6 PUSH: 21 / 21
  - 7 illegal: TRAP_ADDR / TRAP_ADDR, and trap <= 1
- Whenever no stall is active, cur_addr <= address on every edge.
- Latency: an address presented in cycle n appears as controlword in cycle n+1. One microinstruction per cycle when not stalled.
- Dispatch with amode 01/10 while ret_valid = 1: ret_addr is overwritten (no nesting) and ret_valid stays 1.
- trap stays set until reset. Sequencing continues normally from TRAP_ADDR.
- reset asserted mid-stall or mid-subroutine aborts immediately: address = START_ADDR in the same cycle and the return state is cleared.

Test Plan:
- Reset for 2 cycles, then release with nssel=00, dbin=23 -> address=0 during reset; address=23 on the first cycle after release; trap=0.
- nssel=01, opcode=0, amode=01 -> address=1 and ret_addr=10; next a cycle with nssel=10 -> address=10, ret_valid=0.
- nssel=11, dbin=6: zflag=1 -> address=6; zflag=0 -> address=7; dbin=31 with zflag=0 -> address=0.
- memcntl=010, mem_wait=1 for 3 cycles while nssel=00, dbin=7 -> address=cur_addr and stall=1 for 3 cycles; address=7 once mem_wait drops.
- nssel=01, opcode=7 or amode=11, and separately nssel=10 with ret_valid=0 -> address=24 and trap=1 until reset.
- Dispatch amode=10, opcode=1, then assert reset before the return -> address=0; a later return with nssel=10 traps to 24.
